// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding, width helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed for a shift amount (and the iteration counter) at a given width.
    function automatic int shift_bits(input int width);
        return $clog2(width);
    endfunction

    // Opcodes handled by the iterative multiply/divide unit.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unit: WIDTH-step shift-add multiplier and restoring divider.
// Both operations share the {hi, lo} register pair; after the last step it
// holds the 2*WIDTH product, or {remainder, quotient} for a divide.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic               div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic               div_mode,
    output logic [2*WIDTH-1:0] result_next
);

    localparam int SHW = shift_bits(WIDTH);

    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [SHW-1:0]   cnt;
    logic [WIDTH:0]   sum, shifted, trial;

    // Load operands on acceptance, then advance one bit per step.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: no reset here on purpose: load fully initialises these registers
    // before any step, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (load) begin
            hi       <= '0;
            lo       <= div ? a : b;
            opnd     <= div ? b : a;
            div_mode <= div;
            cnt      <= '0;
        end else if (step) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
        end
    end

    // One multiply or divide iteration, computed from the current registers.
    // NOTE: every output gets a default first so no path leaves a value held,
    // which would infer a latch.
    always_comb begin
        sum     = '0;
        shifted = '0;
        trial   = '0;
        hi_n    = hi;
        lo_n    = lo;
        if (div_mode) begin
            // Shift the next dividend bit into the remainder and try subtracting.
            shifted = {hi, lo[WIDTH-1]};
            trial   = shifted - {1'b0, opnd};
            if (!trial[WIDTH]) begin
                hi_n = trial[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add the multiplicand when the current multiplier bit is set, shift right.
            sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

    assign result_next = {hi_n, lo_n};
    assign last        = (cnt == SHW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with Start/Busy/Done handshake. Single-cycle ops finish the cycle
// after acceptance; MUL and DIV (non-zero divisor) run WIDTH steps in the
// iterative unit. Result and flags are registered and held until the next Done.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    input  logic [3:0]         Opcode,
    input  logic [WIDTH-1:0]   Operand1,
    input  logic [WIDTH-1:0]   Operand2,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Result,
    output logic               flagC,
    output logic               flagZ,
    output logic               flagE
);

    localparam int SHW = shift_bits(WIDTH);
    localparam int RW  = 2 * WIDTH;

    state_t          state, state_next;
    logic            it_load, it_step, it_last, it_div;
    logic [RW-1:0]   it_res_next;
    logic            cap, c_d, e_d;
    logic [RW-1:0]   res_d;
    logic [RW-1:0]   sc_res;
    logic            sc_c, sc_e;
    logic [SHW-1:0]  sh;
    logic [WIDTH:0]  sum, diff;
    logic [RW-1:0]   shl_w, shr_w, rol_w, ror_w;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk         (Clk),
        .load        (it_load),
        .step        (it_step),
        .div         (Opcode == OP_DIV),
        .a           (Operand1),
        .b           (Operand2),
        .last        (it_last),
        .div_mode    (it_div),
        .result_next (it_res_next)
    );

    // Single-cycle datapath, evaluated on the live inputs at acceptance.
    always_comb begin
        sh     = Operand2[SHW-1:0];
        sum    = {1'b0, Operand1} + {1'b0, Operand2};
        diff   = {1'b0, Operand1} - {1'b0, Operand2};
        shl_w  = {{WIDTH{1'b0}}, Operand1} << sh;
        shr_w  = {Operand1, {WIDTH{1'b0}}} >> sh;
        rol_w  = {Operand1, Operand1} << sh;
        ror_w  = {Operand1, Operand1} >> sh;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_e   = 1'b0;
        case (Opcode)
            OP_ADD: begin sc_res[WIDTH-1:0] = sum[WIDTH-1:0];  sc_c = sum[WIDTH];  end
            OP_SUB: begin sc_res[WIDTH-1:0] = diff[WIDTH-1:0]; sc_c = diff[WIDTH]; end
            OP_AND: sc_res[WIDTH-1:0] = Operand1 & Operand2;
            OP_OR:  sc_res[WIDTH-1:0] = Operand1 | Operand2;
            OP_XOR: sc_res[WIDTH-1:0] = Operand1 ^ Operand2;
            OP_NOT: sc_res[WIDTH-1:0] = ~Operand1;
            // The last bit shifted out lands just past the kept half.
            OP_SHL: begin sc_res[WIDTH-1:0] = shl_w[WIDTH-1:0];  sc_c = (sh != '0) && shl_w[WIDTH];   end
            OP_SHR: begin sc_res[WIDTH-1:0] = shr_w[RW-1:WIDTH]; sc_c = (sh != '0) && shr_w[WIDTH-1]; end
            OP_ROL: sc_res[WIDTH-1:0] = rol_w[RW-1:WIDTH];
            OP_ROR: sc_res[WIDTH-1:0] = ror_w[WIDTH-1:0];
            OP_MUL: sc_res = '0;
            // Only reached for a zero divisor; non-zero divisors go to the iterative unit.
            OP_DIV: begin sc_res = {Operand1, {WIDTH{1'b1}}}; sc_e = 1'b1; end
            default: sc_e = 1'b1;
        endcase
    end

    // Next state, iterative-unit control and the value to register on completion.
    always_comb begin
        state_next = state;
        it_load    = 1'b0;
        it_step    = 1'b0;
        cap        = 1'b0;
        res_d      = sc_res;
        c_d        = sc_c;
        e_d        = sc_e;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (Start) begin
                    if (is_iter_op(Opcode) && !(Opcode == OP_DIV && Operand2 == '0)) begin
                        state_next = EXEC;
                        it_load    = 1'b1;
                    end else begin
                        state_next = DONE;
                        cap        = 1'b1;
                    end
                end
            end
            EXEC: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_next = DONE;
                    cap        = 1'b1;
                    res_d      = it_res_next;
                    c_d        = !it_div && (|it_res_next[RW-1:WIDTH]);
                    e_d        = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and output registers; flags change only alongside Done.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state  <= IDLE;
            Result <= '0;
            flagC  <= 1'b0;
            flagZ  <= 1'b0;
            flagE  <= 1'b0;
        end else begin
            state <= state_next;
            if (cap) begin
                Result <= res_d;
                flagC  <= c_d;
                flagZ  <= (res_d == '0);
                flagE  <= e_d;
            end
        end
    end

    assign Busy = (state == EXEC);
    assign Done = (state == DONE);

endmodule
